// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM states, NOP word, default fetch window, PC advance.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_ctrl_pkg;

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [31:0] NOP_INST    = 32'h0000_0013;
   localparam logic [31:0] START_ADD   = 32'h0000_0000;
   localparam logic [31:0] INSTADD_END = 32'h0000_FFFC;

   // Sequential fetch stays inside [wrap, last]; anything at or beyond last restarts at wrap.
   function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc,
                                                 input logic [31:0] last,
                                                 input logic [31:0] wrap);
      return (pc < last) ? pc + 32'd4 : wrap;
   endfunction

endpackage

// File: rtl/fetch_ctrl_pc_redirect_arb.sv
// Fixed-priority redirect mux: trap > branch > refetch.
// Purely combinational, zero latency; no backpressure.
module pc_redirect_arb (
   input  logic        trap_req,
   input  logic [31:0] trap_addr,
   input  logic        branch_req,
   input  logic [31:0] branch_addr,
   input  logic        refetch_req,
   input  logic [31:0] refetch_addr,
   output logic        redirect,
   output logic [31:0] target
);

   always_comb begin
      redirect = trap_req | branch_req | refetch_req;
      target   = 32'h0000_0000;
      if (trap_req)
         target = trap_addr;
      else if (branch_req)
         target = branch_addr;
      else if (refetch_req)
         target = refetch_addr;
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one-outstanding ibus fetch, stale-response drop, registered inst/pc to IF/ID.
// Output one cycle after rvalid; requests held off by fetch stall, full output register or redirect.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = START_ADD,
   parameter logic [31:0] END_ADDR   = INSTADD_END
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trap_req_i,
   input  logic [31:0] trap_addr_i,
   input  logic        ex_branch_flag_i,
   input  logic [31:0] ex_branch_addr_i,
   input  logic        refetch_req_i,
   input  logic [31:0] refetch_addr_i,
   input  logic [4:0]  stalled_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o
);

   state_t      state;
   state_t      state_next;
   logic [31:0] fetch_pc;
   logic        drop;
   logic        redirect;
   logic [31:0] target;
   logic        consume;
   logic        out_free;
   logic        fill;
   logic        req;
   logic        unused_stall;

   pc_redirect_arb u_arb (
      .trap_req     (trap_req_i),
      .trap_addr    (trap_addr_i),
      .branch_req   (ex_branch_flag_i),
      .branch_addr  (ex_branch_addr_i),
      .refetch_req  (refetch_req_i),
      .refetch_addr (refetch_addr_i),
      .redirect     (redirect),
      .target       (target)
   );

   assign unused_stall = ^stalled_i[4:2];
   assign consume      = inst_valid_o & ~stalled_i[1];
   assign out_free     = ~inst_valid_o | consume;
   // A response racing a redirect belongs to the old path, same as one already marked stale.
   assign fill         = (state == S_WAIT) & ibus_rvalid_i & ~drop & ~redirect;

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_REQ;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_REQ:   if (req & ibus_gnt_i) state_next = S_WAIT;
         S_WAIT:  if (ibus_rvalid_i)    state_next = S_REQ;
         default: state_next = S_REQ;
      endcase
   end

   always_comb begin
      req = 1'b0;
      if (state == S_REQ && !rst)
         req = ~stalled_i[0] & out_free & ~redirect;
   end

   assign ibus_req_o  = req;
   assign ibus_addr_o = fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc     <= RESET_ADDR;
         drop         <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_INST;
         pc_o         <= RESET_ADDR;
      end else begin
         if (redirect)
            fetch_pc <= target;
         else if (fill)
            fetch_pc <= next_fetch_pc(fetch_pc, END_ADDR, RESET_ADDR);

         if (state == S_WAIT && ibus_rvalid_i)
            drop <= 1'b0;
         else if (state == S_WAIT && redirect)
            drop <= 1'b1;

         if (redirect) begin
            inst_valid_o <= 1'b0;
         end else if (fill) begin
            inst_valid_o <= 1'b1;
            inst_o       <= ibus_rdata_i;
            pc_o         <= fetch_pc;
         end else if (consume) begin
            inst_valid_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state == S_REQ)
         assert (!ibus_rvalid_i) else $error("ibus rvalid with no request outstanding");
   end

endmodule
